// File: rtl/ds18b20_pkg.sv
// Shared constants for the DS18B20 multi-sensor sequencer: engine op codes,
// 1-wire ROM/function command bytes and the sequencer state encoding.
package ds18b20_pkg;

    localparam logic [1:0] OP_RESET = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;

    localparam logic [7:0] CMD_SKIP_ROM  = 8'hCC;
    localparam logic [7:0] CMD_MATCH_ROM = 8'h55;
    localparam logic [7:0] CMD_CONVERT   = 8'h44;
    localparam logic [7:0] CMD_READ_SCR  = 8'hBE;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE   = 4'd0;
    localparam state_t ST_C_RST  = 4'd1;
    localparam state_t ST_C_CC   = 4'd2;
    localparam state_t ST_C_44   = 4'd3;
    localparam state_t ST_POLL   = 4'd4;
    localparam state_t ST_S_RST  = 4'd5;
    localparam state_t ST_S_55   = 4'd6;
    localparam state_t ST_S_ADDR = 4'd7;
    localparam state_t ST_S_BE   = 4'd8;
    localparam state_t ST_S_RD   = 4'd9;
    localparam state_t ST_NEXT   = 4'd10;
    localparam state_t ST_FIN    = 4'd11;

endpackage

// File: rtl/ds18b20_cmd_port.sv
// Single-outstanding command handshake towards the byte-level 1-wire engine.
// An issue strobe latches op/byte and raises cmd_valid; complete marks the response.
module ds18b20_cmd_port
    import ds18b20_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       issue,
    input  logic [1:0] issue_op,
    input  logic [7:0] issue_byte,
    input  logic       cmd_ready,
    input  logic       rsp_valid,
    output logic       idle,
    output logic       complete,
    output logic       cmd_valid,
    output logic [1:0] cmd_op,
    output logic [7:0] cmd_byte
);

    logic waiting;

    assign idle     = !cmd_valid && !waiting;
    // responses outside the wait phase are stray and dropped
    assign complete = waiting && rsp_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_valid <= 1'b0;
            waiting   <= 1'b0;
            cmd_op    <= OP_RESET;
            cmd_byte  <= 8'h00;
        end else if (issue && idle) begin
            cmd_valid <= 1'b1;
            cmd_op    <= issue_op;
            cmd_byte  <= issue_byte;
        end else if (cmd_valid && cmd_ready) begin
            cmd_valid <= 1'b0;
            waiting   <= 1'b1;
        end else if (complete) begin
            waiting   <= 1'b0;
        end
    end

endmodule

// File: rtl/ds18b20_seq_ctrl.sv
// Multi-sensor DS18B20 sequencer: broadcast convert, completion poll, then
// Match ROM + Read Scratchpad for each sensor, streaming scratchpad bytes out.
//
// state     | meaning
// IDLE      | waiting for start
// C_RST     | bus reset before broadcast convert
// C_CC      | Skip ROM write
// C_44      | Convert T write
// POLL      | read slots until conversion completes or poll budget runs out
// S_RST     | bus reset before addressing sensor
// S_55      | Match ROM write
// S_ADDR    | eight ROM byte writes, LSB first
// S_BE      | Read Scratchpad write
// S_RD      | scratchpad byte reads
// NEXT      | advance to next sensor or finish
// FIN       | releasing bus reset, then done
module ds18b20_seq_ctrl
    import ds18b20_pkg::*;
#(
    parameter  int N_SENSORS     = 4,
    parameter  int SCRATCH_BYTES = 9,
    parameter  int POLL_MAX      = 1000,
    localparam int SW            = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [1:0]           cmd_op,
    output logic [7:0]           cmd_byte,
    input  logic                 rsp_valid,
    input  logic [7:0]           rsp_byte,
    output logic [SW-1:0]        addr_sel,
    output logic [2:0]           addr_idx,
    input  logic [7:0]           addr_byte,
    output logic                 data_valid,
    output logic [SW-1:0]        data_sensor,
    output logic [3:0]           data_idx,
    output logic [7:0]           data_byte,
    output logic [N_SENSORS-1:0] err_presence,
    output logic                 err_timeout
);

    localparam int PW = $clog2(POLL_MAX + 1);

    state_t        state, next_state;
    logic [SW-1:0] sensor;
    logic [3:0]    byte_cnt;
    logic [PW-1:0] poll_left;
    logic          is_cmd, issue, port_idle, complete;
    logic [1:0]    cur_op;
    logic [7:0]    cur_byte;
    logic          last_sensor;

    assign last_sensor = (sensor == SW'(N_SENSORS - 1));
    assign addr_sel    = sensor;
    assign addr_idx    = (state == ST_S_ADDR) ? byte_cnt[2:0] : 3'd0;
    assign issue       = is_cmd && port_idle;

    always_comb begin
        is_cmd   = 1'b1;
        cur_op   = OP_WRITE;
        cur_byte = 8'h00;
        case (state)
            ST_C_RST, ST_S_RST, ST_FIN: cur_op = OP_RESET;
            ST_C_CC:   cur_byte = CMD_SKIP_ROM;
            ST_C_44:   cur_byte = CMD_CONVERT;
            ST_S_55:   cur_byte = CMD_MATCH_ROM;
            ST_S_ADDR: cur_byte = addr_byte;
            ST_S_BE:   cur_byte = CMD_READ_SCR;
            ST_POLL, ST_S_RD: begin
                cur_op   = OP_READ;
                cur_byte = 8'hFF;
            end
            default:   is_cmd = 1'b0;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (start && !done) next_state = ST_C_RST;
            ST_C_RST:  if (complete) next_state = rsp_byte[0] ? ST_C_CC : ST_FIN;
            ST_C_CC:   if (complete) next_state = ST_C_44;
            ST_C_44:   if (complete) next_state = ST_POLL;
            ST_POLL: begin
                if (complete) begin
                    if (rsp_byte != 8'h00)          next_state = ST_S_RST;
                    else if (poll_left <= PW'(1))   next_state = ST_FIN;
                end
            end
            ST_S_RST:  if (complete) next_state = rsp_byte[0] ? ST_S_55 : ST_NEXT;
            ST_S_55:   if (complete) next_state = ST_S_ADDR;
            ST_S_ADDR: if (complete && byte_cnt == 4'd7) next_state = ST_S_BE;
            ST_S_BE:   if (complete) next_state = ST_S_RD;
            ST_S_RD:   if (complete && byte_cnt == 4'(SCRATCH_BYTES - 1)) next_state = ST_NEXT;
            ST_NEXT:   next_state = last_sensor ? ST_FIN : ST_S_RST;
            ST_FIN:    if (complete) next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            sensor       <= '0;
            byte_cnt     <= 4'd0;
            poll_left    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            data_valid   <= 1'b0;
            data_sensor  <= '0;
            data_idx     <= 4'd0;
            data_byte    <= 8'h00;
            err_presence <= '0;
            err_timeout  <= 1'b0;
        end else begin
            state      <= next_state;
            done       <= (state == ST_FIN) && complete;
            data_valid <= (state == ST_S_RD) && complete;

            if (next_state != state)
                byte_cnt <= 4'd0;
            else if (complete && (state == ST_S_ADDR || state == ST_S_RD))
                byte_cnt <= byte_cnt + 4'd1;

            case (state)
                ST_IDLE: if (next_state == ST_C_RST) begin
                    busy         <= 1'b1;
                    err_presence <= '0;
                    err_timeout  <= 1'b0;
                end
                ST_C_RST: if (complete && !rsp_byte[0]) err_presence <= '1;
                ST_C_44:  if (complete) poll_left <= PW'(POLL_MAX);
                // poll budget is a down-counter; terminal count 1 ends the poll
                ST_POLL: if (complete) begin
                    if (next_state == ST_S_RST)  sensor      <= '0;
                    else if (next_state == ST_FIN) err_timeout <= 1'b1;
                    else                         poll_left   <= poll_left - PW'(1);
                end
                ST_S_RST: if (complete && !rsp_byte[0]) err_presence[sensor] <= 1'b1;
                ST_S_RD: if (complete) begin
                    data_sensor <= sensor;
                    data_idx    <= byte_cnt;
                    data_byte   <= rsp_byte;
                end
                ST_NEXT: if (!last_sensor) sensor <= sensor + 1'b1;
                ST_FIN:  if (complete) busy <= 1'b0;
                default: ;
            endcase
        end
    end

    ds18b20_cmd_port u_cmd_port (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue      (issue),
        .issue_op   (cur_op),
        .issue_byte (cur_byte),
        .cmd_ready  (cmd_ready),
        .rsp_valid  (rsp_valid),
        .idle       (port_idle),
        .complete   (complete),
        .cmd_valid  (cmd_valid),
        .cmd_op     (cmd_op),
        .cmd_byte   (cmd_byte)
    );

endmodule

// File: tb/tb_ds18b20_seq_ctrl.sv
// Directed bench for ds18b20_seq_ctrl: a 1-wire engine model answers commands,
// command and data streams are logged and compared against hand-built expectations.
module tb_ds18b20_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, start, busy, done;
    logic       cmd_valid, cmd_ready, rsp_valid;
    logic [1:0] cmd_op;
    logic [7:0] cmd_byte, rsp_byte, addr_byte, data_byte;
    logic [0:0] addr_sel, data_sensor;
    logic [2:0] addr_idx;
    logic       data_valid, err_timeout;
    logic [3:0] data_idx;
    logic [1:0] err_presence;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int stab_err = 0;

    logic [9:0]  got_cmd[$], exp_cmd[$];
    logic [12:0] got_dat[$], exp_dat[$];

    // engine model knobs and state
    bit [3:0] pres;
    int       poll_zeros;
    bit       stall_en;
    int       m_rst, m_be, m_rd, m_poll;

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_of(input logic [0:0] s, input logic [2:0] i);
        return (s ? 8'hA0 : 8'h30) + {5'd0, i};
    endfunction

    assign addr_byte = rom_of(addr_sel, addr_idx);

    ds18b20_seq_ctrl #(.N_SENSORS(2), .SCRATCH_BYTES(9), .POLL_MAX(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_byte(cmd_byte),
        .rsp_valid(rsp_valid), .rsp_byte(rsp_byte),
        .addr_sel(addr_sel), .addr_idx(addr_idx), .addr_byte(addr_byte),
        .data_valid(data_valid), .data_sensor(data_sensor), .data_idx(data_idx), .data_byte(data_byte),
        .err_presence(err_presence), .err_timeout(err_timeout)
    );

    // engine: accept each command, then answer after an optional random delay
    initial begin
        logic [1:0] e_op;
        logic [7:0] e_b, r;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_byte  = 8'h00;
        forever begin
            @(negedge clk);
            if (cmd_valid) begin
                if (stall_en) repeat ($urandom_range(0, 20)) @(negedge clk);
                e_op = cmd_op;
                e_b  = cmd_byte;
                cmd_ready = 1'b1;
                @(negedge clk);
                cmd_ready = 1'b0;
                r = 8'h00;
                case (e_op)
                    2'd0: begin
                        r = {7'd0, (m_rst < 4) ? pres[m_rst] : 1'b0};
                        m_rst++;
                    end
                    2'd1: if (e_b == 8'hBE) begin
                        m_be++;
                        m_rd = 0;
                    end
                    default: begin
                        if (m_be == 0) begin
                            r = (m_poll < poll_zeros) ? 8'h00 : 8'h01;
                            m_poll++;
                        end else begin
                            r = 8'(16 * m_be + m_rd);
                            m_rd++;
                        end
                    end
                endcase
                if (stall_en) repeat ($urandom_range(0, 20)) @(negedge clk);
                rsp_byte  = r;
                rsp_valid = 1'b1;
                @(negedge clk);
                rsp_valid = 1'b0;
                rsp_byte  = 8'h00;
            end
        end
    end

    // monitor: sampled just after the falling edge, when inputs and outputs are settled
    initial begin
        logic       pv_stall;
        logic [1:0] pv_op;
        logic [7:0] pv_byte;
        pv_stall = 1'b0;
        pv_op    = 2'd0;
        pv_byte  = 8'h00;
        forever begin
            @(negedge clk);
            #1;
            if (pv_stall && !(cmd_valid && cmd_op == pv_op && cmd_byte == pv_byte)) stab_err++;
            pv_stall = cmd_valid && !cmd_ready;
            pv_op    = cmd_op;
            pv_byte  = cmd_byte;
            if (cmd_valid && cmd_ready) got_cmd.push_back({cmd_op, cmd_byte});
            if (data_valid) got_dat.push_back({data_sensor, data_idx, data_byte});
            if (done) done_cnt++;
        end
    end

    task automatic model_clear(input bit [3:0] p, input int zeros, input bit stall);
        pres = p;
        poll_zeros = zeros;
        stall_en = stall;
        m_rst = 0; m_be = 0; m_rd = 0; m_poll = 0;
        got_cmd.delete();
        got_dat.delete();
        done_cnt = 0;
    endtask

    // p[0]=convert presence, p[1]/p[2]=sensor presence; poll answers 'zeros' zeros then nonzero
    task automatic build_exp(input bit [3:0] p, input int zeros, input bit tmo);
        int k = 0;
        exp_cmd.delete();
        exp_dat.delete();
        exp_cmd.push_back({2'd0, 8'h00});
        if (p[0]) begin
            exp_cmd.push_back({2'd1, 8'hCC});
            exp_cmd.push_back({2'd1, 8'h44});
            for (int i = 0; i < (tmo ? 5 : zeros + 1); i++) exp_cmd.push_back({2'd2, 8'hFF});
            if (!tmo) begin
                for (int s = 0; s < 2; s++) begin
                    exp_cmd.push_back({2'd0, 8'h00});
                    if (p[s + 1]) begin
                        k++;
                        exp_cmd.push_back({2'd1, 8'h55});
                        for (int i = 0; i < 8; i++) exp_cmd.push_back({2'd1, rom_of(1'(s), 3'(i))});
                        exp_cmd.push_back({2'd1, 8'hBE});
                        for (int i = 0; i < 9; i++) begin
                            exp_cmd.push_back({2'd2, 8'hFF});
                            exp_dat.push_back({1'(s), 4'(i), 8'(16 * k + i)});
                        end
                    end
                end
            end
        end
        exp_cmd.push_back({2'd0, 8'h00});
    endtask

    function automatic int cmd_diff();
        for (int i = 0; i < got_cmd.size() && i < exp_cmd.size(); i++)
            if (got_cmd[i] !== exp_cmd[i]) return i;
        if (got_cmd.size() != exp_cmd.size())
            return (got_cmd.size() < exp_cmd.size()) ? got_cmd.size() : exp_cmd.size();
        return -1;
    endfunction

    function automatic int dat_diff();
        for (int i = 0; i < got_dat.size() && i < exp_dat.size(); i++)
            if (got_dat[i] !== exp_dat[i]) return i;
        if (got_dat.size() != exp_dat.size())
            return (got_dat.size() < exp_dat.size()) ? got_dat.size() : exp_dat.size();
        return -1;
    endfunction

    task automatic run_seq(input string name);
        int n = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_start got %b exp 1", name, busy);
        end
        while (done_cnt == 0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL %s done_wait got no done within %0d cycles exp done pulse", name, n);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, cmd_valid, cmd_op, cmd_byte, addr_sel, addr_idx, data_valid,
             data_sensor, data_idx, data_byte, err_presence, err_timeout} !== 34'd0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b cv=%b op=%h b=%h ds=%h di=%h db=%h ep=%b et=%b exp all 0",
                     busy, done, cmd_valid, cmd_op, cmd_byte, data_sensor, data_idx, data_byte, err_presence, err_timeout);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if ({busy, cmd_valid} !== 2'b00) begin
            errors++;
            $display("FAIL idle_no_start got busy=%b cmd_valid=%b exp 0 0", busy, cmd_valid);
        end
    endtask

    task automatic test_all_present();
        int i;
        model_clear(4'b0111, 2, 1'b0);
        build_exp(4'b0111, 2, 1'b0);
        run_seq("all_present");
        i = cmd_diff();
        checks++;
        if (i >= 0) begin
            errors++;
            $display("FAIL all_present cmd[%0d] got %h (len %0d) exp %h (len %0d)", i, got_cmd[i], got_cmd.size(), exp_cmd[i], exp_cmd.size());
        end
        i = dat_diff();
        checks++;
        if (i >= 0) begin
            errors++;
            $display("FAIL all_present data[%0d] got %h (len %0d) exp %h (len %0d)", i, got_dat[i], got_dat.size(), exp_dat[i], exp_dat.size());
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL all_present done_pulses got %0d exp 1", done_cnt);
        end
        checks++;
        if ({err_presence, err_timeout, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL all_present flags got ep=%b et=%b busy=%b exp 00 0 0", err_presence, err_timeout, busy);
        end
    endtask

    task automatic test_sensor_absent();
        int i;
        model_clear(4'b0011, 2, 1'b0);
        build_exp(4'b0011, 2, 1'b0);
        run_seq("sensor1_absent");
        i = cmd_diff();
        checks++;
        if (i >= 0) begin
            errors++;
            $display("FAIL sensor1_absent cmd[%0d] got %h (len %0d) exp %h (len %0d)", i, got_cmd[i], got_cmd.size(), exp_cmd[i], exp_cmd.size());
        end
        i = dat_diff();
        checks++;
        if (i >= 0) begin
            errors++;
            $display("FAIL sensor1_absent data[%0d] got %h (len %0d) exp %h (len %0d)", i, got_dat[i], got_dat.size(), exp_dat[i], exp_dat.size());
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL sensor1_absent done_pulses got %0d exp 1", done_cnt);
        end
        checks++;
        if ({err_presence, err_timeout} !== 3'b100) begin
            errors++;
            $display("FAIL sensor1_absent flags got ep=%b et=%b exp 10 0", err_presence, err_timeout);
        end
    endtask

    task automatic test_convert_absent();
        int i;
        model_clear(4'b0000, 2, 1'b0);
        build_exp(4'b0000, 2, 1'b0);
        run_seq("convert_absent");
        i = cmd_diff();
        checks++;
        if (i >= 0) begin
            errors++;
            $display("FAIL convert_absent cmd[%0d] got %h (len %0d) exp %h (len %0d)", i, got_cmd[i], got_cmd.size(), exp_cmd[i], exp_cmd.size());
        end
        checks++;
        if (got_dat.size() !== 0 || done_cnt !== 1) begin
            errors++;
            $display("FAIL convert_absent data_done got data=%0d done=%0d exp 0 1", got_dat.size(), done_cnt);
        end
        checks++;
        if ({err_presence, err_timeout} !== 3'b110) begin
            errors++;
            $display("FAIL convert_absent flags got ep=%b et=%b exp 11 0", err_presence, err_timeout);
        end
    endtask

    task automatic test_timeout();
        int i;
        model_clear(4'b0001, 1000, 1'b0);
        build_exp(4'b0001, 1000, 1'b1);
        run_seq("poll_timeout");
        i = cmd_diff();
        checks++;
        if (i >= 0) begin
            errors++;
            $display("FAIL poll_timeout cmd[%0d] got %h (len %0d) exp %h (len %0d)", i, got_cmd[i], got_cmd.size(), exp_cmd[i], exp_cmd.size());
        end
        checks++;
        if (got_dat.size() !== 0 || done_cnt !== 1) begin
            errors++;
            $display("FAIL poll_timeout data_done got data=%0d done=%0d exp 0 1", got_dat.size(), done_cnt);
        end
        checks++;
        if ({err_presence, err_timeout} !== 3'b001) begin
            errors++;
            $display("FAIL poll_timeout flags got ep=%b et=%b exp 00 1", err_presence, err_timeout);
        end
    endtask

    task automatic test_stalls();
        int i;
        model_clear(4'b0111, 2, 1'b1);
        build_exp(4'b0111, 2, 1'b0);
        stab_err = 0;
        run_seq("stalls");
        stall_en = 1'b0;
        i = cmd_diff();
        checks++;
        if (i >= 0) begin
            errors++;
            $display("FAIL stalls cmd[%0d] got %h (len %0d) exp %h (len %0d)", i, got_cmd[i], got_cmd.size(), exp_cmd[i], exp_cmd.size());
        end
        i = dat_diff();
        checks++;
        if (i >= 0) begin
            errors++;
            $display("FAIL stalls data[%0d] got %h (len %0d) exp %h (len %0d)", i, got_dat[i], got_dat.size(), exp_dat[i], exp_dat.size());
        end
        checks++;
        if (stab_err !== 0) begin
            errors++;
            $display("FAIL stalls cmd_stable got %0d unstable cycles exp 0", stab_err);
        end
        checks++;
        if ({done_cnt == 1, err_presence, err_timeout} !== 4'b1000) begin
            errors++;
            $display("FAIL stalls done_flags got done=%0d ep=%b et=%b exp 1 00 0", done_cnt, err_presence, err_timeout);
        end
    endtask

    task automatic test_reset_mid();
        int i;
        int n = 0;
        model_clear(4'b0111, 2, 1'b0);
        build_exp(4'b0111, 2, 1'b0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (got_dat.size() < 3 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (got_dat.size() < 3) begin
            errors++;
            $display("FAIL reset_mid reach_rd got %0d bytes exp 3", got_dat.size());
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, cmd_valid, cmd_op, cmd_byte, addr_sel, addr_idx, data_valid,
             data_sensor, data_idx, data_byte, err_presence, err_timeout} !== 34'd0) begin
            errors++;
            $display("FAIL reset_mid outputs got busy=%b done=%b cv=%b op=%h b=%h dv=%b db=%h exp all 0",
                     busy, done, cmd_valid, cmd_op, cmd_byte, data_valid, data_byte);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        checks++;
        if (done_cnt !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid no_done got done=%0d busy=%b exp 0 0", done_cnt, busy);
        end
        model_clear(4'b0111, 2, 1'b0);
        run_seq("after_reset");
        i = cmd_diff();
        checks++;
        if (i >= 0) begin
            errors++;
            $display("FAIL after_reset cmd[%0d] got %h (len %0d) exp %h (len %0d)", i, got_cmd[i], got_cmd.size(), exp_cmd[i], exp_cmd.size());
        end
        i = dat_diff();
        checks++;
        if (i >= 0) begin
            errors++;
            $display("FAIL after_reset data[%0d] got %h (len %0d) exp %h (len %0d)", i, got_dat[i], got_dat.size(), exp_dat[i], exp_dat.size());
        end
    endtask

    task automatic test_back_to_back();
        int i;
        int n = 0;
        model_clear(4'b0111, 2, 1'b0);
        build_exp(4'b0111, 2, 1'b0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!done && n < 20000) begin
            @(negedge clk);
            n++;
        end
        // start during the done cycle is dropped, one cycle later it is taken
        start = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b start_on_done got busy=%b exp 0", busy);
        end
        i = cmd_diff();
        checks++;
        if (i >= 0 || done_cnt !== 1) begin
            errors++;
            $display("FAIL b2b first_run cmd[%0d] got %h (len %0d, done %0d) exp %h (len %0d, done 1)", i, got_cmd[i], got_cmd.size(), done_cnt, exp_cmd[i], exp_cmd.size());
        end
        model_clear(4'b0111, 2, 1'b0);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b start_after_done got busy=%b exp 1", busy);
        end
        n = 0;
        while (done_cnt == 0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        i = cmd_diff();
        checks++;
        if (i >= 0) begin
            errors++;
            $display("FAIL b2b second_run cmd[%0d] got %h (len %0d) exp %h (len %0d)", i, got_cmd[i], got_cmd.size(), exp_cmd[i], exp_cmd.size());
        end
        i = dat_diff();
        checks++;
        if (i >= 0 || done_cnt !== 1) begin
            errors++;
            $display("FAIL b2b second_run data[%0d] got %h (len %0d, done %0d) exp %h (len %0d, done 1)", i, got_dat[i], got_dat.size(), done_cnt, exp_dat[i], exp_dat.size());
        end
    endtask

    initial begin
        stall_en = 1'b0;
        pres = 4'b0000;
        poll_zeros = 0;
        m_rst = 0; m_be = 0; m_rd = 0; m_poll = 0;
        test_reset();
        test_all_present();
        test_sensor_absent();
        test_convert_absent();
        test_timeout();
        test_stalls();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
